// File: rtl/dso100fb_layer_regs.sv
// Purpose : APB3 register slave for the multi-layer DSO100 framebuffer: per-layer
//           double-buffered fetch registers (BASE/LENGTH/CTRL), START/STOP control
//           pulses and an interrupt controller (NUM_IRQ external + commit-done).
// Latency : zero-wait-state APB; PRDATA registered in setup phase; START/STOP,
//           COMMIT_DONE and INTR are registered one cycle after their cause.
// Backpressure: none, PREADY is tied high; unmapped accesses raise PSLVERR.
// Ports   : CLK/RST (async active-high); APB3 slave PADDR..PSLVERR; START/STOP
//           pulses out; STATE in (read via CR); IRQ_IN pulses in; FRAME_START in;
//           LAYER_BASE/LAYER_LENGTH/LAYER_EN active copies out; COMMIT_DONE; INTR.
// Option  : define DSO100FB_FRAME_COUNTER_EN to add the FRAMECNT register at 0x10.
module dso100fb_layer_regs #(
  parameter int NUM_LAYERS = 4,
  parameter int NUM_IRQ    = 2,
  parameter int ADDR_W     = 12,
  parameter int LEN_W      = 23
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [31:0]                 PWDATA,
  output logic [31:0]                 PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic                        START,
  output logic                        STOP,
  input  logic [1:0]                  STATE,
  input  logic [NUM_IRQ-1:0]          IRQ_IN,
  input  logic                        FRAME_START,
  output logic [32*NUM_LAYERS-1:0]    LAYER_BASE,
  output logic [LEN_W*NUM_LAYERS-1:0] LAYER_LENGTH,
  output logic [NUM_LAYERS-1:0]       LAYER_EN,
  output logic                        COMMIT_DONE,
  output logic                        INTR
);
  localparam int WA_W = ADDR_W - 2;  // word address width
  localparam int SL_W = ADDR_W - 4;  // 16-byte slot index width
  localparam int IS_W = NUM_IRQ + 1; // ISR/IMR width, top bit is commit-done

  // Register state
  logic [31:0]      r_prdata;
  logic             r_start, r_stop;
  logic [IS_W-1:0]  r_isr, r_imr;
  logic             r_intr;
  logic             r_pending;
  logic             r_commit_done;
  logic [31:0]      r_sh_base  [NUM_LAYERS];
  logic [LEN_W-1:0] r_sh_len   [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_sh_en;
  logic [31:0]      r_act_base [NUM_LAYERS];
  logic [LEN_W-1:0] r_act_len  [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_act_en;
`ifdef DSO100FB_FRAME_COUNTER_EN
  logic [31:0]      r_framecnt;
`endif

  // Address decode
  logic [WA_W-1:0] w_word;
  logic [SL_W-1:0] w_slot;
  logic [1:0]      w_sub;
  logic            w_unused;
  logic            w_hit_cr, w_hit_isr, w_hit_imr, w_hit_commit, w_hit_fcnt;
  logic [NUM_LAYERS-1:0] w_hit_layer;
  logic            w_mapped;
  logic [31:0]     w_rdata;
  logic            w_wr;
  logic            w_commit;
  logic [IS_W-1:0] w_isr_clr, w_isr_set;

  assign w_word   = PADDR[ADDR_W-1:2];
  assign w_slot   = w_word[WA_W-1:2];
  assign w_sub    = w_word[1:0];
  assign w_unused = ^PADDR[1:0];  // byte lanes are not decoded

  always_comb begin
    w_rdata      = '0;
    w_hit_layer  = '0;
    w_hit_cr     = (w_word == WA_W'(0));
    w_hit_isr    = (w_word == WA_W'(1));
    w_hit_imr    = (w_word == WA_W'(2));
    w_hit_commit = (w_word == WA_W'(3));
`ifdef DSO100FB_FRAME_COUNTER_EN
    w_hit_fcnt   = (w_word == WA_W'(4));
`else
    w_hit_fcnt   = 1'b0;
`endif
    // Layer i lives in 16-byte slot 4+i; the fourth word of each slot is a hole.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_hit_layer[i] = (w_slot == SL_W'(4 + i)) && (w_sub != 2'd3);
    end
    w_mapped = w_hit_cr | w_hit_isr | w_hit_imr | w_hit_commit | w_hit_fcnt | (|w_hit_layer);

    if (w_hit_cr)     w_rdata[3:2]      = STATE;
    if (w_hit_isr)    w_rdata[IS_W-1:0] = r_isr;
    if (w_hit_imr)    w_rdata[IS_W-1:0] = r_imr;
    if (w_hit_commit) w_rdata[0]        = r_pending;
`ifdef DSO100FB_FRAME_COUNTER_EN
    if (w_hit_fcnt)   w_rdata           = r_framecnt;
`endif
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (w_hit_layer[i]) begin
        case (w_sub)
          2'd0:    w_rdata             = r_sh_base[i];
          2'd1:    w_rdata[LEN_W-1:0]  = r_sh_len[i];
          default: w_rdata[0]          = r_sh_en[i];
        endcase
      end
    end
  end

  assign w_wr      = PSEL & PENABLE & PWRITE;
  assign w_commit  = FRAME_START & r_pending;
  assign w_isr_clr = (w_wr & w_hit_isr) ? PWDATA[IS_W-1:0] : '0;
  assign w_isr_set = {w_commit, IRQ_IN};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prdata      <= '0;
      r_start       <= 1'b0;
      r_stop        <= 1'b0;
      r_isr         <= '0;
      r_imr         <= '0;
      r_intr        <= 1'b0;
      r_pending     <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      if (PSEL & ~PENABLE) r_prdata <= w_rdata;
      r_start <= w_wr & w_hit_cr & PWDATA[0];
      r_stop  <= w_wr & w_hit_cr & PWDATA[1];
      // Clear first, then set, so a coincident source pulse keeps the bit.
      r_isr   <= (r_isr & ~w_isr_clr) | w_isr_set;
      if (w_wr & w_hit_imr) r_imr <= PWDATA[IS_W-1:0];
      r_intr  <= |(r_isr & r_imr);
      // An applied commit always retires the request; a write only arms it.
      if (w_commit)                              r_pending <= 1'b0;
      else if (w_wr & w_hit_commit & PWDATA[0])  r_pending <= 1'b1;
      r_commit_done <= w_commit;
    end
  end

  // Shadow/active layer sets. Active copies sample the shadows before any
  // same-edge shadow write lands, so a racing write waits for the next commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sh_en  <= '0;
      r_act_en <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_sh_base[i]  <= '0;
        r_sh_len[i]   <= '0;
        r_act_base[i] <= '0;
        r_act_len[i]  <= '0;
      end
    end else begin
      if (w_commit) r_act_en <= r_sh_en;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (w_commit) begin
          r_act_base[i] <= r_sh_base[i];
          r_act_len[i]  <= r_sh_len[i];
        end
        if (w_wr & w_hit_layer[i]) begin
          case (w_sub)
            2'd0:    r_sh_base[i] <= PWDATA;
            2'd1:    r_sh_len[i]  <= PWDATA[LEN_W-1:0];
            default: r_sh_en[i]   <= PWDATA[0];
          endcase
        end
      end
    end
  end

`ifdef DSO100FB_FRAME_COUNTER_EN
  // Software clear beats a coincident frame tick.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      r_framecnt <= '0;
    else if (w_wr & w_hit_fcnt)   r_framecnt <= '0;
    else if (FRAME_START)         r_framecnt <= r_framecnt + 32'd1;
  end
`endif

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer_out
    assign LAYER_BASE[32*g +: 32]         = r_act_base[g];
    assign LAYER_LENGTH[LEN_W*g +: LEN_W] = r_act_len[g];
  end
  assign LAYER_EN    = r_act_en;
  assign PRDATA      = r_prdata;
  assign PREADY      = 1'b1;
  assign PSLVERR     = PSEL & PENABLE & ~w_mapped;
  assign START       = r_start;
  assign STOP        = r_stop;
  assign COMMIT_DONE = r_commit_done;
  assign INTR        = r_intr;
endmodule

// File: tb/tb_dso100fb_layer_regs.sv
// Scoreboard bench for dso100fb_layer_regs: APB expectations and commit snapshots
// are queued at issue time from a register-map model; monitors pop and compare.
module tb_dso100fb_layer_regs;
  localparam int NL = 4, NI = 2, AW = 12, LW = 23;

  logic CLK = 1'b0, RST = 1'b1;
  logic [AW-1:0] PADDR = '0;
  logic PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic PREADY, PSLVERR, START, STOP;
  logic [1:0] STATE = '0;
  logic [NI-1:0] IRQ_IN = '0;
  logic FRAME_START = 1'b0;
  logic [32*NL-1:0] LAYER_BASE;
  logic [LW*NL-1:0] LAYER_LENGTH;
  logic [NL-1:0] LAYER_EN;
  logic COMMIT_DONE, INTR;

  dso100fb_layer_regs #(.NUM_LAYERS(NL), .NUM_IRQ(NI), .ADDR_W(AW), .LEN_W(LW)) dut (
    .CLK(CLK), .RST(RST), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .START(START), .STOP(STOP), .STATE(STATE), .IRQ_IN(IRQ_IN),
    .FRAME_START(FRAME_START), .LAYER_BASE(LAYER_BASE), .LAYER_LENGTH(LAYER_LENGTH),
    .LAYER_EN(LAYER_EN), .COMMIT_DONE(COMMIT_DONE), .INTR(INTR));

  always #5 CLK = ~CLK;

  typedef struct { bit rd; logic [31:0] data; bit err; logic [11:0] addr; } apb_exp_t;
  typedef struct packed { logic [32*NL-1:0] base; logic [LW*NL-1:0] len; logic [NL-1:0] en; } snap_t;

  apb_exp_t apb_q[$];
  snap_t    cq[$];
  int checks = 0, errors = 0;
  bit rand_ev = 0;

  // Reference model of the register map
  logic [31:0]   m_sh_base[NL], m_act_base[NL];
  logic [LW-1:0] m_sh_len[NL],  m_act_len[NL];
  logic          m_sh_en[NL],   m_act_en[NL];
  logic [2:0]    m_isr, m_imr;
  logic          m_pending, m_start, m_stop, m_intr;
  logic [31:0]   m_fcnt;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_sh_base[i] = 0; m_sh_len[i] = 0; m_sh_en[i] = 0;
      m_act_base[i] = 0; m_act_len[i] = 0; m_act_en[i] = 0;
    end
    m_isr = 0; m_imr = 0; m_pending = 0; m_start = 0; m_stop = 0; m_intr = 0; m_fcnt = 0;
  endtask

  function automatic snap_t act_snap();
    snap_t s;
    for (int i = 0; i < NL; i++) begin
      s.base[32*i +: 32] = m_act_base[i];
      s.len[LW*i +: LW]  = m_act_len[i];
      s.en[i]            = m_act_en[i];
    end
    return s;
  endfunction

  task automatic m_decode(input logic [11:0] a, output bit mapped, output logic [31:0] d);
    int off, rel, li, ri;
    off = int'(a) & 'hFFC;
    mapped = 1; d = 0;
    if (off == 0) d = {28'd0, STATE, 2'b00};
    else if (off == 4)  d = {29'd0, m_isr};
    else if (off == 8)  d = {29'd0, m_imr};
    else if (off == 12) d = {31'd0, m_pending};
`ifdef DSO100FB_FRAME_COUNTER_EN
    else if (off == 16) d = m_fcnt;
`endif
    else if (off >= 64) begin
      rel = off - 64; li = rel / 16; ri = (rel % 16) / 4;
      if (li < NL && ri < 3) begin
        if (ri == 0) d = m_sh_base[li];
        else if (ri == 1) d = {9'd0, m_sh_len[li]};
        else d = {31'd0, m_sh_en[li]};
      end else mapped = 0;
    end else mapped = 0;
  endtask

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_step();
    bit wr, mapped, commit;
    logic [31:0] rd;
    int off, li, ri;
    if (RST) begin model_reset(); return; end
    wr = PSEL && PENABLE && PWRITE;
    m_decode(PADDR, mapped, rd);
    wr = wr && mapped;
    off = int'(PADDR) & 'hFFC;
    m_intr  = (m_isr & m_imr) != 0;
    commit  = FRAME_START && m_pending;
    m_start = wr && off == 0 && PWDATA[0];
    m_stop  = wr && off == 0 && PWDATA[1];
    if (commit) begin
      for (int i = 0; i < NL; i++) begin
        m_act_base[i] = m_sh_base[i]; m_act_len[i] = m_sh_len[i]; m_act_en[i] = m_sh_en[i];
      end
      cq.push_back(act_snap());
      m_pending = 0;
    end
    if (wr && off == 4) m_isr = m_isr & ~PWDATA[2:0];
    m_isr = m_isr | {1'b0, IRQ_IN} | (commit ? 3'b100 : 3'b000);
    if (wr && off == 8) m_imr = PWDATA[2:0];
    if (wr && off == 12 && PWDATA[0] && !commit) m_pending = 1;
`ifdef DSO100FB_FRAME_COUNTER_EN
    if (wr && off == 16) m_fcnt = 0;
    else if (FRAME_START) m_fcnt = m_fcnt + 1;
`endif
    if (wr && off >= 64) begin
      li = (off - 64) / 16; ri = ((off - 64) % 16) / 4;
      if (ri == 0) m_sh_base[li] = PWDATA;
      else if (ri == 1) m_sh_len[li] = PWDATA[LW-1:0];
      else m_sh_en[li] = PWDATA[0];
    end
  endtask

  task automatic tick();
    if (rand_ev) begin
      FRAME_START = ($urandom_range(0, 3) == 0);
      IRQ_IN = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    end
    @(posedge CLK);
    model_step();
    #1;
    FRAME_START = 0;
    IRQ_IN = 0;
  endtask

  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic fs_acc, input logic [1:0] irq_acc);
    bit mapped;
    logic [31:0] rd;
    apb_exp_t e;
    STATE = 2'($urandom_range(0, 3));
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
    m_decode(a, mapped, rd);
    e.rd = !wr; e.data = rd; e.err = !mapped; e.addr = a;
    apb_q.push_back(e);
    tick();
    PENABLE = 1;
    if (fs_acc) FRAME_START = 1;
    if (irq_acc != 0) IRQ_IN = irq_acc;
    tick();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d); apb(1, a, d, 0, 2'b00); endtask
  task automatic rd(input logic [11:0] a); apb(0, a, 0, 0, 2'b00); endtask

  task automatic read_all();
    rd(12'h000); rd(12'h004); rd(12'h008); rd(12'h00C); rd(12'h010);
    for (int i = 0; i < NL; i++)
      for (int r = 0; r < 3; r++) rd(12'(64 + 16 * i + 4 * r));
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 12'(4 * $urandom_range(0, 5));
      1, 2, 3: return 12'(64 + 16 * $urandom_range(0, 4) + 4 * $urandom_range(0, 3) + $urandom_range(0, 3));
      4:       return 12'h7FC;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // Monitor: APB responses, commit snapshots and per-cycle output state.
  always @(negedge CLK) begin
    apb_exp_t e;
    snap_t s, a;
    if (PSEL && PENABLE) begin
      if (apb_q.size() == 0) chk("apb_unexpected_access", 1, 0);
      else begin
        e = apb_q.pop_front();
        chk($sformatf("pslverr@%03h", e.addr), 128'(PSLVERR), 128'(e.err));
        if (e.rd) chk($sformatf("prdata@%03h", e.addr), 128'(PRDATA), 128'(e.data));
      end
    end
    a = act_snap();
    if (COMMIT_DONE) begin
      if (cq.size() == 0) chk("commit_done_unexpected", 1, 0);
      else begin
        s = cq.pop_front();
        chk("commit_base", 128'(LAYER_BASE), 128'(s.base));
        chk("commit_len", 128'(LAYER_LENGTH), 128'(s.len));
        chk("commit_en", 128'(LAYER_EN), 128'(s.en));
      end
    end else if (cq.size() != 0) begin
      chk("commit_done_missing", 128'(COMMIT_DONE), 1);
      cq.delete();
    end
    chk("start", 128'(START), 128'(m_start));
    chk("stop", 128'(STOP), 128'(m_stop));
    chk("intr", 128'(INTR), 128'(m_intr));
    chk("layer_base", 128'(LAYER_BASE), 128'(a.base));
    chk("layer_len", 128'(LAYER_LENGTH), 128'(a.len));
    chk("layer_en", 128'(LAYER_EN), 128'(a.en));
  end

  initial begin
    model_reset();
    RST = 1;
    repeat (3) tick();
    RST = 0;
    chk("pready", 128'(PREADY), 1);
    chk("reset_layer_en", 128'(LAYER_EN), 0);
    chk("reset_intr", 128'(INTR), 0);
    read_all();

    // Shadow writes do not reach the active set without a commit.
    wr(12'h050, 32'h1000_0000); wr(12'h054, 32'h0003_8400); wr(12'h058, 1);
    rd(12'h050); rd(12'h054); rd(12'h058);
    FRAME_START = 1; tick(); tick();
    chk("no_commit_base1", 128'(LAYER_BASE[63:32]), 0);

    // Commit then frame start.
    wr(12'h00C, 1); rd(12'h00C);
    FRAME_START = 1; tick();
    chk("commit_base1", 128'(LAYER_BASE[63:32]), 128'(32'h1000_0000));
    chk("commit_len1", 128'(LAYER_LENGTH[2*LW-1:LW]), 128'(23'h03_8400));
    chk("commit_en1", 128'(LAYER_EN[1]), 1);
    rd(12'h00C);

    // COMMIT write coincident with FRAME_START waits for the next frame.
    wr(12'h040, 32'hA5A5_0000);
    apb(1, 12'h00C, 1, 1, 2'b00);
    chk("late_commit_base0", 128'(LAYER_BASE[31:0]), 0);
    rd(12'h00C);
    FRAME_START = 1; tick();
    chk("next_frame_base0", 128'(LAYER_BASE[31:0]), 128'(32'hA5A5_0000));

    // Shadow write on the commit edge: active takes the old shadow.
    wr(12'h00C, 1);
    apb(1, 12'h040, 32'h1234_5678, 1, 2'b00);
    chk("race_active_base0", 128'(LAYER_BASE[31:0]), 128'(32'hA5A5_0000));
    rd(12'h040);

    // Interrupts: commit-done source, W1C with coincident set, plain clear.
    wr(12'h008, 4); wr(12'h00C, 1);
    FRAME_START = 1; tick(); tick();
    chk("intr_on_commit", 128'(INTR), 1);
    rd(12'h004);
    apb(1, 12'h004, 4, 0, 2'b01);
    tick();
    chk("intr_after_clear", 128'(INTR), 0);
    rd(12'h004);
    apb(1, 12'h004, 1, 0, 2'b01);
    rd(12'h004);
    wr(12'h004, 7); rd(12'h004);

    // START/STOP pulses.
    wr(12'h000, 3);
    chk("start_pulse", 128'(START), 1);
    chk("stop_pulse", 128'(STOP), 1);
    tick();
    chk("start_low", 128'(START), 0);

    // Unmapped addresses.
    rd(12'h7FC); wr(12'h7FC, 32'hFFFF_FFFF); rd(12'h080); rd(12'h04C); rd(12'h014); rd(12'h010);

`ifdef DSO100FB_FRAME_COUNTER_EN
    wr(12'h010, 0);
    repeat (3) begin FRAME_START = 1; tick(); end
    rd(12'h010);
    apb(1, 12'h010, 5, 1, 2'b00);
    rd(12'h010);
`endif

    // Reset mid-frame with pending commit, ISR bits and a live START pulse.
    wr(12'h008, 7); wr(12'h048, 1); wr(12'h00C, 1);
    FRAME_START = 1; tick();
    wr(12'h00C, 1);
    IRQ_IN = 2'b11; tick(); tick();
    wr(12'h000, 1);
    #1;
    RST = 1;
    model_reset(); apb_q.delete(); cq.delete();
    #1;
    chk("rst_start", 128'(START), 0);
    chk("rst_layer_en", 128'(LAYER_EN), 0);
    chk("rst_layer_base", 128'(LAYER_BASE), 0);
    chk("rst_intr", 128'(INTR), 0);
    chk("rst_commit_done", 128'(COMMIT_DONE), 0);
    tick(); tick();
    RST = 0;
    read_all();

    // Randomised traffic with random frame and IRQ pulses.
    rand_ev = 1;
    repeat (500) begin
      case ($urandom_range(0, 2))
        0: wr(rand_addr(), $urandom);
        1: rd(rand_addr());
        default: repeat ($urandom_range(1, 3)) tick();
      endcase
    end
    rand_ev = 0;
    repeat (3) tick();
    chk("apb_queue_drained", 128'(apb_q.size()), 0);
    chk("commit_queue_drained", 128'(cq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
